// File: rtl/spi_shift_reg_param.sv
//==============================================================================
// Module   : spi_shift_reg_param
// Purpose  : Parametrised SPI shifter: TX serialiser / RX assembler for all
//            CPOL/CPHA modes, driven by baud-generator SCK edge strobes.
//            Optional SPI_OVERRUN_DET_EN adds the sticky overrun output.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_shift_reg_param #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              ss,
   input  logic              send_data,
   input  logic              receive_data,
   input  logic              lsbfe,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [CNT_W-1:0]  frame_len,
   input  logic              flag_high,
   input  logic              flag_low,
   input  logic [DATA_W-1:0] data_mosi,
   input  logic              miso,
   output logic              mosi,
   output logic [DATA_W-1:0] data_miso,
   output logic              busy,
   output logic              frame_done,
`ifdef SPI_OVERRUN_DET_EN
   output logic              overrun,
`endif
   output logic [CNT_W-1:0]  bit_cnt
);

   localparam int PTR_W = $clog2(DATA_W);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] data_miso_q, data_miso_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic              lsbfe_q, lsbfe_d;
   logic              cpol_q, cpol_d;
   logic              cpha_q, cpha_d;
   logic              first_edge_q, first_edge_d;
   logic              mosi_q, mosi_d;
   logic              frame_done_q, frame_done_d;

   logic [CNT_W-1:0]  w_eff_len;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_load;
   logic              w_hi;
   logic              w_lo;
   logic              w_sample;
   logic              w_shift;
   logic              w_last;

   assign w_eff_len = ((frame_len == '0) || (frame_len > CNT_W'(DATA_W))) ?
                      CNT_W'(DATA_W) : frame_len;
   assign w_cnt_inc = bit_cnt_q + CNT_W'(1);
   assign w_load    = (state_q == ST_IDLE) && send_data && !ss;

   // A coincident flag_low is dropped so flag_high always wins
   assign w_hi      = flag_high;
   assign w_lo      = flag_low & ~flag_high;
   assign w_sample  = (cpol_q == cpha_q) ? w_hi : w_lo;
   assign w_shift   = (cpol_q == cpha_q) ? w_lo : w_hi;
   assign w_last    = (state_q == ST_SHIFT) && !ss && w_sample && (w_cnt_inc == len_q);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (w_load)        state_d = ST_SHIFT;
         ST_SHIFT: if (ss || w_last)  state_d = ST_IDLE;
         default:                     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q == ST_SHIFT);
      mosi       = mosi_q;
      data_miso  = data_miso_q;
      frame_done = frame_done_q;
      bit_cnt    = bit_cnt_q;
   end

   always_comb begin
      tx_d         = tx_q;
      rx_d         = rx_q;
      ptr_d        = ptr_q;
      bit_cnt_d    = bit_cnt_q;
      len_d        = len_q;
      lsbfe_d      = lsbfe_q;
      cpol_d       = cpol_q;
      cpha_d       = cpha_q;
      first_edge_d = first_edge_q;
      frame_done_d = 1'b0;
      data_miso_d  = data_miso_q;

      // Reads the pre-load rx so a coincident send_data returns the old frame
      if (receive_data) begin
         data_miso_d = rx_q;
      end

      if (w_load) begin
         tx_d         = data_mosi;
         len_d        = w_eff_len;
         lsbfe_d      = lsbfe;
         cpol_d       = cpol;
         cpha_d       = cpha;
         ptr_d        = lsbfe ? '0 : (w_eff_len[PTR_W-1:0] - PTR_W'(1));
         bit_cnt_d    = '0;
         rx_d         = '0;
         first_edge_d = 1'b1;
      end else if (state_q == ST_SHIFT) begin
         if (ss) begin
            bit_cnt_d = '0;
         end else if (w_sample) begin
            if (lsbfe_q) begin
               rx_d[bit_cnt_q[PTR_W-1:0]] = miso;
            end else begin
               rx_d = {rx_q[DATA_W-2:0], miso};
            end
            bit_cnt_d    = w_cnt_inc;
            frame_done_d = w_last;
         end else if (w_shift && (bit_cnt_q != len_q)) begin
            // cpha=1 leading edge only arms shifting; bit 0 is already out
            if (cpha_q && first_edge_q) begin
               first_edge_d = 1'b0;
            end else if (lsbfe_q) begin
               ptr_d = ptr_q + PTR_W'(1);
            end else begin
               ptr_d = ptr_q - PTR_W'(1);
            end
         end
      end

      mosi_d = (state_d == ST_SHIFT) ? tx_d[ptr_d] : 1'b0;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         tx_q         <= '0;
         rx_q         <= '0;
         ptr_q        <= '0;
         bit_cnt_q    <= '0;
         len_q        <= '0;
         lsbfe_q      <= 1'b0;
         cpol_q       <= 1'b0;
         cpha_q       <= 1'b0;
         first_edge_q <= 1'b0;
         mosi_q       <= 1'b0;
         frame_done_q <= 1'b0;
         data_miso_q  <= '0;
      end else begin
         tx_q         <= tx_d;
         rx_q         <= rx_d;
         ptr_q        <= ptr_d;
         bit_cnt_q    <= bit_cnt_d;
         len_q        <= len_d;
         lsbfe_q      <= lsbfe_d;
         cpol_q       <= cpol_d;
         cpha_q       <= cpha_d;
         first_edge_q <= first_edge_d;
         mosi_q       <= mosi_d;
         frame_done_q <= frame_done_d;
         data_miso_q  <= data_miso_d;
      end
   end

`ifdef SPI_OVERRUN_DET_EN
   logic rx_full_q, rx_full_d;
   logic overrun_q, overrun_d;

   always_comb begin
      rx_full_d = rx_full_q;
      overrun_d = overrun_q;
      if (frame_done_q && receive_data) begin
         rx_full_d = 1'b1;
      end else if (receive_data) begin
         rx_full_d = 1'b0;
         overrun_d = 1'b0;
      end else if (frame_done_q) begin
         rx_full_d = 1'b1;
         overrun_d = overrun_q | rx_full_q;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rx_full_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         rx_full_q <= rx_full_d;
         overrun_q <= overrun_d;
      end
   end

   assign overrun = overrun_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_shift_reg_param.sv
//==============================================================================
// Module   : tb_spi_shift_reg_param
// Purpose  : Randomised self-checking bench for spi_shift_reg_param against a
//            frame-level reference model (bit order, length, RX word).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spi_shift_reg_param;

   localparam int DW = 16;
   localparam int CW = $clog2(DW) + 1;

   logic          PCLK;
   logic          PRESETn;
   logic          ss;
   logic          send_data;
   logic          receive_data;
   logic          lsbfe;
   logic          cpol;
   logic          cpha;
   logic [CW-1:0] frame_len;
   logic          flag_high;
   logic          flag_low;
   logic [DW-1:0] data_mosi;
   logic          miso;
   logic          mosi;
   logic [DW-1:0] data_miso;
   logic          busy;
   logic          frame_done;
   logic [CW-1:0] bit_cnt;
`ifdef SPI_OVERRUN_DET_EN
   logic          overrun;
`endif

   int            n_vec;
   int            n_err;
   logic [DW-1:0] model_rx;

   spi_shift_reg_param #(.DATA_W(DW)) dut (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .ss           (ss),
      .send_data    (send_data),
      .receive_data (receive_data),
      .lsbfe        (lsbfe),
      .cpol         (cpol),
      .cpha         (cpha),
      .frame_len    (frame_len),
      .flag_high    (flag_high),
      .flag_low     (flag_low),
      .data_mosi    (data_mosi),
      .miso         (miso),
      .mosi         (mosi),
      .data_miso    (data_miso),
      .busy         (busy),
      .frame_done   (frame_done),
`ifdef SPI_OVERRUN_DET_EN
      .overrun      (overrun),
`endif
      .bit_cnt      (bit_cnt)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic pulse(input bit hi);
      if (hi) flag_high = 1'b1;
      else    flag_low  = 1'b1;
      tick();
      flag_high = 1'b0;
      flag_low  = 1'b0;
   endtask

   // One complete frame: SCK modelled as 2 edges per bit starting from idle level cpol
   task automatic run_frame(input logic [DW-1:0] data, input logic [CW-1:0] flen,
                            input bit lsb, input bit cp, input bit ch,
                            input logic [DW-1:0] mbits, input bit do_rx,
                            input bit dup_send, input bit rx_at_load);
      int            L;
      logic [DW-1:0] exp_rx;
      logic [DW-1:0] prev_rx;
      bit            lead_hi;
      bit            eb;
      bit            smp;
      L = ((flen == 0) || (int'(flen) > DW)) ? DW : int'(flen);
      exp_rx = '0;
      for (int k = 0; k < L; k++) exp_rx[lsb ? k : L-1-k] = mbits[k];
      prev_rx = model_rx;

      data_mosi = data; frame_len = flen; lsbfe = lsb; cpol = cp; cpha = ch;
      send_data = 1'b1; receive_data = rx_at_load;
      tick();
      send_data = 1'b0; receive_data = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || bit_cnt !== '0) begin
         n_err++;
         $display("FAIL load: busy=%b bit_cnt=%0d, want busy=1 bit_cnt=0", busy, bit_cnt);
      end
      if (rx_at_load) begin
         n_vec++;
         if (data_miso !== prev_rx) begin
            n_err++;
            $display("FAIL rx_at_load: data_miso=%h want %h", data_miso, prev_rx);
         end
      end
      // Scramble config inputs: the frame must keep the latched copy
      {lsbfe, cpol, cpha} = 3'($urandom);
      frame_len = CW'($urandom);
      data_mosi = DW'($urandom);
      lead_hi   = !cp;

      for (int k = 0; k < L; k++) begin
         eb   = lsb ? data[k] : data[L-1-k];
         miso = mbits[k];
         if (dup_send && k == 1) begin
            send_data = 1'b1;
            tick();
            send_data = 1'b0;
         end
         for (int j = 0; j < 2; j++) begin
            smp = ((j == 0) == !ch);
            if (smp) begin
               n_vec++;
               if (mosi !== eb) begin
                  n_err++;
                  $display("FAIL mosi bit %0d: got %b want %b", k, mosi, eb);
               end
            end
            pulse((j == 0) ? lead_hi : !lead_hi);
            if (smp) begin
               n_vec++;
               if (bit_cnt !== CW'(k+1) || frame_done !== (k == L-1) || busy !== (k != L-1)) begin
                  n_err++;
                  $display("FAIL sample %0d: bit_cnt=%0d done=%b busy=%b want %0d %b %b",
                           k, bit_cnt, frame_done, busy, k+1, (k == L-1), (k != L-1));
               end
            end
            tick();
         end
      end

      n_vec++;
      if (busy !== 1'b0 || mosi !== 1'b0 || frame_done !== 1'b0) begin
         n_err++;
         $display("FAIL post_frame: busy=%b mosi=%b done=%b want 0 0 0", busy, mosi, frame_done);
      end
      model_rx = exp_rx;
      if (do_rx) begin
         receive_data = 1'b1;
         tick();
         receive_data = 1'b0;
         n_vec++;
         if (data_miso !== exp_rx) begin
            n_err++;
            $display("FAIL data_miso: got %h want %h", data_miso, exp_rx);
         end
      end
   endtask

   task automatic test_reset();
      PRESETn = 1'b0;
      tick(); tick();
      n_vec++;
      if ({mosi, busy, frame_done} !== 3'b000 || data_miso !== '0 || bit_cnt !== '0) begin
         n_err++;
         $display("FAIL reset: mosi=%b busy=%b done=%b data_miso=%h bit_cnt=%0d want all 0",
                  mosi, busy, frame_done, data_miso, bit_cnt);
      end
`ifdef SPI_OVERRUN_DET_EN
      n_vec++;
      if (overrun !== 1'b0) begin
         n_err++;
         $display("FAIL reset_overrun: got %b want 0", overrun);
      end
`endif
      PRESETn = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      run_frame(16'h00A5, CW'(8), 1'b0, 1'b0, 1'b0, 16'h003C, 1'b1, 1'b0, 1'b0);
      run_frame(16'h8001, CW'(0), 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      run_frame(16'h0009, CW'(4), 1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_abort();
      data_mosi = DW'($urandom); frame_len = CW'(8);
      lsbfe = 1'b0; cpol = 1'b0; cpha = 1'b0;
      send_data = 1'b1;
      tick();
      send_data = 1'b0;
      for (int k = 0; k < 3; k++) begin
         miso = (k != 1);
         pulse(1'b1); tick();
         pulse(1'b0); tick();
      end
      n_vec++;
      if (bit_cnt !== CW'(3)) begin
         n_err++;
         $display("FAIL abort_pre: bit_cnt=%0d want 3", bit_cnt);
      end
      ss = 1'b1;
      tick();
      n_vec++;
      if ({busy, frame_done, mosi} !== 3'b000 || bit_cnt !== '0) begin
         n_err++;
         $display("FAIL abort: busy=%b done=%b mosi=%b bit_cnt=%0d want 0", busy, frame_done, mosi, bit_cnt);
      end
      pulse(1'b1); tick();
      n_vec++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_after: done=%b busy=%b want 0 0", frame_done, busy);
      end
      send_data = 1'b1;
      tick();
      send_data = 1'b0;
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL send_with_ss_high: busy=%b want 0", busy);
      end
      receive_data = 1'b1;
      tick();
      receive_data = 1'b0;
      n_vec++;
      if (data_miso !== 16'h0005) begin
         n_err++;
         $display("FAIL abort_partial_rx: data_miso=%h want 0005", data_miso);
      end
      model_rx = 16'h0005;
      ss = 1'b0;
      tick();
      run_frame(DW'($urandom), CW'(8), 1'b0, 1'b0, 1'b0, DW'($urandom), 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_ignored();
      run_frame(DW'($urandom), CW'(6), 1'b1, 1'b1, 1'b0, DW'($urandom), 1'b1, 1'b1, 1'b0);
      pulse(1'b1); tick();
      pulse(1'b0); tick();
      flag_high = 1'b1; flag_low = 1'b1;
      tick();
      flag_high = 1'b0; flag_low = 1'b0;
      n_vec++;
      if (bit_cnt !== CW'(6) || mosi !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
         n_err++;
         $display("FAIL idle_strobes: bit_cnt=%0d mosi=%b busy=%b done=%b want 6 0 0 0",
                  bit_cnt, mosi, busy, frame_done);
      end
   endtask

   task automatic test_reset_mid();
      data_mosi = DW'($urandom); frame_len = CW'(0);
      lsbfe = 1'b0; cpol = 1'b0; cpha = 1'b0;
      send_data = 1'b1;
      tick();
      send_data = 1'b0;
      miso = 1'b1;
      for (int k = 0; k < 2; k++) begin
         pulse(1'b1); tick();
         pulse(1'b0); tick();
      end
      receive_data = 1'b1;
      tick();
      receive_data = 1'b0;
      n_vec++;
      if (data_miso !== 16'h0003 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL mid_partial: data_miso=%h busy=%b want 0003 1", data_miso, busy);
      end
      #3 PRESETn = 1'b0;
      #1;
      n_vec++;
      if ({mosi, busy, frame_done} !== 3'b000 || data_miso !== '0 || bit_cnt !== '0) begin
         n_err++;
         $display("FAIL async_reset: mosi=%b busy=%b done=%b data_miso=%h bit_cnt=%0d want 0",
                  mosi, busy, frame_done, data_miso, bit_cnt);
      end
      tick();
      PRESETn = 1'b1;
      model_rx = '0;
      tick();
   endtask

`ifdef SPI_OVERRUN_DET_EN
   task automatic test_overrun();
      receive_data = 1'b1;
      tick();
      receive_data = 1'b0;
      run_frame(DW'($urandom), CW'(8), 1'b0, 1'b0, 1'b0, DW'($urandom), 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (overrun !== 1'b0) begin
         n_err++;
         $display("FAIL overrun_first: got %b want 0", overrun);
      end
      run_frame(DW'($urandom), CW'(8), 1'b1, 1'b1, 1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (overrun !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_second: got %b want 1", overrun);
      end
      receive_data = 1'b1;
      tick();
      receive_data = 1'b0;
      n_vec++;
      if (overrun !== 1'b0 || data_miso !== model_rx) begin
         n_err++;
         $display("FAIL overrun_clear: overrun=%b data_miso=%h want 0 %h", overrun, data_miso, model_rx);
      end
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         run_frame(DW'($urandom), CW'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
                   1'($urandom), DW'($urandom), 1'b1, ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 2) == 0));
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; model_rx = '0;
      PRESETn = 1'b0; ss = 1'b0; send_data = 1'b0; receive_data = 1'b0;
      lsbfe = 1'b0; cpol = 1'b0; cpha = 1'b0; frame_len = '0;
      flag_high = 1'b0; flag_low = 1'b0; data_mosi = '0; miso = 1'b0;
      test_reset();
      test_directed();
      test_abort();
      test_ignored();
      test_reset_mid();
`ifdef SPI_OVERRUN_DET_EN
      test_overrun();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/spi_shift_reg_param.md
Name: spi_shift_reg_param

Overview:
Parametrised successor of the SPI core's fixed 8-bit shifter. Serialises a TX word onto mosi and assembles a right-justified RX word from miso.
- Frame length is programmable per frame (1..DATA_W bits); LSB/MSB-first order is selectable.
- All four CPOL/CPHA modes are derived internally from the baud generator's SCK edge strobes.
- Adds busy/frame_done handshake and abort on slave-select release. Sits between the SPI register/control block and the baud generator.

Parameters:
DATA_W, 16, maximum frame width in bits (>=2)
CNT_W, $clog2(DATA_W)+1, width of frame_len and bit_cnt

Ports:
PCLK  in  1  system clock; all state on rising edge
PRESETn  in  1  asynchronous active-low reset
ss  in  1  slave select, active low; high aborts frame
send_data  in  1  1-cycle strobe: load data_mosi and start frame
receive_data  in  1  1-cycle strobe: copy RX assembly register to data_miso
lsbfe  in  1  1 = LSB first, 0 = MSB first (latched at load)
cpol  in  1  clock polarity (latched at load)
cpha  in  1  clock phase (latched at load)
frame_len  in  CNT_W  bits per frame; 0 or >DATA_W means DATA_W (latched at load)
flag_high  in  1  1-cycle strobe coincident with SCK rising edge
flag_low  in  1  1-cycle strobe coincident with SCK falling edge
data_mosi  in  DATA_W  TX word, right-justified
miso  in  1  serial input
mosi  out  1  serial output
data_miso  out  DATA_W  RX word, right-justified, zero above frame length
busy  out  1  frame in progress
frame_done  out  1  1-cycle pulse after last sample
bit_cnt  out  CNT_W  bits sampled so far in current frame

Behaviour:
- Reset values: mosi=0, data_miso=0, busy=0, frame_done=0, bit_cnt=0. The TX register, RX assembly register, pointer and latched config are also cleared.
- States: IDLE, SHIFT. Reset and abort go to IDLE.
- IDLE->SHIFT: on send_data with ss=0. In the same edge:
  - latch data_mosi, config and effective length L;
  - ptr = L-1 (MSB first) or 0 (LSB first); bit_cnt=0; RX assembly register cleared; first_edge=1.
- send_data with ss=1 or while busy: ignored.
- busy=1 exactly while in SHIFT.
- mosi (SHIFT): tx_reg[ptr], registered, so it is valid the cycle after load. This meets cpha=0 setup before the first sample edge. mosi=0 in IDLE.
- Edge roles:
  - sample edge = flag_high when cpol==cpha, otherwise flag_low;
  - shift edge = the opposite strobe.
- If both strobes are high in one cycle: flag_high processed, flag_low ignored.
- Sample edge (SHIFT):
  - MSB first: rx <= {rx[DATA_W-2:0], miso}.
  - LSB first: rx[bit_cnt] <= miso.
  - bit_cnt++.
  - If bit_cnt becomes L: frame_done=1 for 1 cycle, state->IDLE, busy=0 on the same edge.
- Shift edge (SHIFT):
  - cpha=1 with first_edge=1: clear first_edge only; ptr unchanged, since the leading edge presents bit 0, which is already on mosi.
  - Otherwise: ptr-- (MSB first) or ptr++ (LSB first).
  - No shift is performed once bit_cnt==L.
- Strobes in IDLE: ignored.
- receive_data: data_miso <= rx (bits >= L are zero). Allowed in any state; mid-frame it returns the partial word. The same cycle as send_data is legal and returns the previous frame, because the clear happens in parallel.
- ss rising mid-frame: next edge goes to IDLE, bit_cnt=0, mosi=0, no frame_done. rx is retained until the next load.
- Reset asserted mid-frame: immediate asynchronous return to reset values.
- Config inputs change mid-frame: no effect until the next load.

Optional Feature:
SPI_OVERRUN_DET_EN
- When defined, adds output `overrun` (1 bit, reset 0) and internal `rx_full`:
  - frame_done sets rx_full; receive_data clears it.
  - frame_done while rx_full=1 sets overrun (sticky).
  - overrun is cleared by receive_data or reset.
  - frame_done and receive_data in the same cycle: rx_full stays 1 and overrun is unchanged.
- When not defined: no overrun port and no rx_full logic.

Test Plan:
- DATA_W=16, mode 0, MSB first, frame_len=8, data_mosi=0x00A5, miso stream 0,0,1,1,1,1,0,0 -> mosi 1,0,1,0,0,1,0,1; frame_done after 8th flag_high; receive_data -> data_miso=0x003C.
- Mode 3, LSB first, frame_len=0 (=16), data_mosi=0x8001, miso constant 1 -> mosi 1, then 0 x14, then 1; frame_done after 16 flag_high; data_miso=0xFFFF.
- Mode 1 (cpol=0, cpha=1), MSB first, len=4, data_mosi=0x9 -> first flag_high does not move ptr; mosi 1,0,0,1 sampled on flag_low; bit_cnt 1..4; busy drops with frame_done.
- Abort: len=8, ss->1 after 3 sample edges -> busy=0, bit_cnt=0, mosi=0, no frame_done; a following send_data with ss=0 starts cleanly.
- Ignored strobes: send_data while busy, and flag_high/flag_low in IDLE -> no change to tx, bit_cnt or mosi. Reset pulsed mid-frame -> all outputs 0 asynchronously.
- SPI_OVERRUN_DET_EN: two back-to-back 8-bit frames without receive_data -> overrun=1 after 2nd frame_done; receive_data -> overrun=0, data_miso = second frame.
